// File: rtl/load_store_unit.sv
// Load/store unit: memory-stage to req/gnt/rvalid data bus bridge.
// Byte enables, store lane replication, load alignment and extension.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t state_nx;

  logic        op;
  logic        is_wr;
  logic        is_ld;
  logic        mis_c;
  logic        mis_ld;
  logic        go;
  logic        cap;
  logic        abort;
  logic        tmo;
  logic [1:0]  off;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] sh;
  logic [31:0] ld_c;
  logic [31:0] rd_q;

  assign op     = mem_read_en | mem_write_en;
  assign is_wr  = mem_write_en;
  assign is_ld  = mem_read_en & ~mem_write_en;
  assign off    = address[1:0];
  assign mis_c  = ((size == 2'b01) & off[0])
                | (size[1] & (off != 2'b00));
  assign misaligned = op & mis_c;
  assign mis_ld = (state == IDLE) & is_ld & mis_c;
  assign go     = (state == IDLE) & op & ~mis_c;
  assign tmo    = (cnt >= LIMIT);
  assign sh     = bus_rdata >> {off_q, 3'b000};
  assign read_data = mis_ld ? 32'h0 : rd_q;

  // Store byte enables and lane replication
  always_comb begin
    be_c = 4'hF;
    wd_c = write_data;
    unique case (1'b1)
      (size == 2'b00): begin
        be_c = 4'b0001 << off;
        wd_c = {4{write_data[7:0]}};
      end
      (size == 2'b01): begin
        be_c = 4'b0011 << off;
        wd_c = {2{write_data[15:0]}};
      end
      default: ;
    endcase
    if (!is_wr) be_c = 4'hF;
  end

  // Load alignment and sign/zero extension
  always_comb begin
    ld_c = sh;
    unique case (1'b1)
      (size_q == 2'b00):
        ld_c = {{24{~uns_q & sh[7]}}, sh[7:0]};
      (size_q == 2'b01):
        ld_c = {{16{~uns_q & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

  // Next state, stall and completion strobes
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    cap      = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          stall    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_gnt && bus_we) begin
          state_nx = DONE;
        end else if (bus_gnt && bus_rvalid) begin
          cap      = 1'b1;
          state_nx = DONE;
        end else if (tmo) begin
          abort    = 1'b1;
          state_nx = DONE;
        end else if (bus_gnt) begin
          state_nx = RSP;
        end
      end
      RSP: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          cap      = 1'b1;
          state_nx = DONE;
        end else if (tmo) begin
          abort    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Bus fields, timeout counter and load result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_err   <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      cnt       <= '0;
      rd_q      <= 32'h0;
    end else begin
      bus_req <= (state_nx == REQ);
      bus_err <= abort;
      if (go) begin
        bus_we    <= is_wr;
        bus_addr  <= {address[31:2], 2'b00};
        bus_be    <= be_c;
        bus_wdata <= wd_c;
        off_q     <= off;
        size_q    <= size;
        uns_q     <= load_unsigned;
        cnt       <= '0;
      end else if (state == REQ || state == RSP) begin
        cnt <= cnt + 1'b1;
      end
      if (cap)                  rd_q <= ld_c;
      else if (abort || mis_ld) rd_q <= 32'h0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit.
// Reactive bus responder, transaction-level reference model.
module tb_load_store_unit;

  localparam int T = 6;

  logic        clk;
  logic        rst;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] read_data;
  logic        stall;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  load_store_unit #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en),
    .address(address),
    .write_data(write_data),
    .size(size),
    .load_unsigned(load_unsigned),
    .read_data(read_data),
    .stall(stall),
    .misaligned(misaligned),
    .bus_err(bus_err),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        mis;
    int          stall_n;
    int          req_n;
    int          err_n;
    logic [31:0] rd;
    logic        acc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          fails;
  logic [31:0] rd_model;

  int   g;
  int   r;
  int   k;
  logic rsp_wait;
  logic late_rv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h",
               n, act, req);
    end
  endtask

  // Bus slave: grant after g request cycles, data r cycles later
  always @(negedge clk) begin
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    if (!rst || !stall) begin
      rsp_wait = 1'b0;
      k        = 0;
    end else if (bus_req || rsp_wait) begin
      if (bus_req && k == g) begin
        bus_gnt = 1'b1;
        if (!bus_we) begin
          if (r == 0) bus_rvalid = 1'b1;
          else        rsp_wait   = 1'b1;
        end
      end else if (rsp_wait && k == g + r) begin
        bus_rvalid = 1'b1;
        rsp_wait   = 1'b0;
      end
      k++;
    end
    if (late_rv) bus_rvalid = 1'b1;
  end

  int          st_n;
  int          rq_n;
  int          er_n;
  logic        got;
  logic        c_we;
  logic [31:0] c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_wd;

  // Monitor: observe each instruction, compare on retire
  always @(negedge clk) begin
    exp_t e;
    if (!rst || !(mem_read_en || mem_write_en)) begin
      st_n = 0;
      rq_n = 0;
      er_n = 0;
      got  = 1'b0;
    end else begin
      if (bus_req && !got) begin
        got    = 1'b1;
        c_we   = bus_we;
        c_addr = bus_addr;
        c_be   = bus_be;
        c_wd   = bus_wdata;
      end
      if (bus_req) rq_n++;
      if (bus_err) er_n++;
      if (stall) begin
        st_n++;
      end else begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL retire_unexpected actual=1 required=0");
        end else begin
          e = q.pop_front();
          chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
          chk("stall_cycles", 32'(st_n), 32'(e.stall_n));
          chk("req_cycles", 32'(rq_n), 32'(e.req_n));
          chk("bus_err_cycles", 32'(er_n), 32'(e.err_n));
          chk("read_data", read_data, e.rd);
          if (e.acc) begin
            chk("bus_we", {31'b0, c_we}, {31'b0, e.we});
            chk("bus_addr", c_addr, e.addr);
            chk("bus_be", {28'b0, c_be}, {28'b0, e.be});
            if (e.we) chk("bus_wdata", c_wd, e.wd);
          end
        end
        st_n = 0;
        rq_n = 0;
        er_n = 0;
        got  = 1'b0;
      end
    end
  end

  task automatic issue(input logic re, input logic we,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [1:0] sz,
                       input logic un,
                       input int gg, input int rr,
                       input logic [31:0] rdat);
    exp_t        e;
    int          nb;
    int          c;
    int          o;
    logic [31:0] mask;
    logic [31:0] v;
    bit          done;
    o  = int'(a[1:0]);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.mis = (nb == 2 && (o % 2) != 0) || (nb == 4 && o != 0);
    e.acc = !e.mis;
    e.we  = we;
    e.addr = a & 32'hFFFF_FFFC;
    e.be  = we ? 4'(((1 << nb) - 1) << o) : 4'hF;
    if (nb == 1)      e.wd = wd[7:0] * 32'h0101_0101;
    else if (nb == 2) e.wd = wd[15:0] * 32'h0001_0001;
    else              e.wd = wd;
    e.stall_n = 0;
    e.req_n   = 0;
    e.err_n   = 0;
    if (e.mis) begin
      if (re && !we) rd_model = 32'h0;
    end else begin
      c = we ? gg : gg + rr;
      if (c <= T - 1) begin
        e.stall_n = c + 2;
        e.req_n   = gg + 1;
        if (re && !we) begin
          v = rdat >> (8 * o);
          if (nb < 4) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v = v & mask;
            if (!un && v[8*nb-1]) v = v | ~mask;
          end
          rd_model = v;
        end
      end else begin
        e.stall_n = T + 1;
        e.req_n   = (gg < T) ? gg + 1 : T;
        e.err_n   = 1;
        rd_model  = 32'h0;
      end
    end
    e.rd = rd_model;
    q.push_back(e);
    g = gg;
    r = rr;
    bus_rdata     = rdat;
    mem_read_en   = re;
    mem_write_en  = we;
    address       = a;
    write_data    = wd;
    size          = sz;
    load_unsigned = un;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL retire_timeout actual=stalled required=retire");
    end
    @(posedge clk);
    #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    checks = 0;
    fails = 0;
    rd_model = 32'h0;
    g = 0;
    r = 0;
    late_rv = 1'b0;
    rst = 1'b0;
    mem_read_en = 1'b0;
    mem_write_en = 1'b0;
    address = 32'h0;
    write_data = 32'h0;
    size = 2'b00;
    load_unsigned = 1'b0;
    bus_rdata = 32'h0;
    #3;
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 1, 32'h103, 32'hAB, 2'b00, 0, 0, 0, 0);
    issue(1, 0, 32'h102, 0, 2'b01, 0, 0, 0, 32'h8001_1234);
    issue(1, 0, 32'h102, 0, 2'b01, 1, 0, 1, 32'h8001_1234);
    issue(1, 0, 32'h200, 0, 2'b10, 0, 3, 2, 32'hCAFE_F00D);
    issue(1, 0, 32'h101, 0, 2'b01, 0, 0, 0, 32'h1111_1111);
    issue(0, 1, 32'h102, 32'h55, 2'b10, 0, 0, 0, 0);
    issue(1, 1, 32'h302, 32'h1234_5678, 2'b01, 0, 1, 0, 0);
    issue(1, 0, 32'h400, 0, 2'b11, 0, 0, 0, 32'h9ABC_DEF0);
    issue(1, 0, 32'h404, 0, 2'b10, 0, 9, 0, 32'h1);
    issue(1, 0, 32'h408, 0, 2'b00, 1, 2, 4, 32'h2);
    issue(0, 1, 32'h40C, 32'h77, 2'b10, 0, 5, 0, 0);
    issue(1, 0, 32'h501, 0, 2'b00, 0, 0, 0, 32'h0000_8000);

    mem_read_en = 1'b1;
    address = 32'h600;
    size = 2'b10;
    g = 3;
    r = 0;
    @(negedge clk);
    @(negedge clk);
    chk("req_before_rst", {31'b0, bus_req}, 32'h1);
    rst = 1'b0;
    mem_read_en = 1'b0;
    #1;
    chk("rst_async_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_async_stall", {31'b0, stall}, 32'h0);
    chk("rst_async_read_data", read_data, 32'h0);
    rd_model = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    late_rv = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    late_rv = 1'b0;
    chk("late_rv_bus_req", {31'b0, bus_req}, 32'h0);
    chk("late_rv_stall", {31'b0, stall}, 32'h0);
    chk("late_rv_read_data", read_data, 32'h0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      logic re;
      logic we;
      int   sel;
      sel = $urandom_range(0, 7);
      re = (sel < 4) || (sel == 7);
      we = (sel >= 4);
      issue(re, we, $urandom, $urandom,
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ?
              $urandom_range(0, 8) : $urandom_range(0, 2),
            $urandom_range(0, 3), $urandom);
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
